// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one main-memory beat port between the icache (line reads) and the
// dcache (line reads and dirty-line write-backs). Whole cache-line
// transactions are granted round-robin and sequenced as BEATS beats. Read
// beats come back in order and are registered into the owning cache's
// response port.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   ic_req_*_i / ic_req_*_o    icache line-read request / grant pulse
//   ic_rsp_*_o                 icache read beats (registered)
//   dc_req_*_i / dc_req_*_o    dcache line request (rtype 0 rd, 1 wr) / grant
//   dc_wdata_i/dc_wdata_ready_o  current write beat / beat accepted by memory
//   dc_rsp_*_o                 dcache read beats (registered)
//   dc_wr_done_o               write-back complete pulse (registered)
//   mem_req_*_o / mem_req_ready_i  memory beat request channel
//   mem_rsp_*_i                in-order memory read beats
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 128,
    parameter int BEATS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // icache
    input  logic          ic_req_valid_i,
    output logic          ic_req_ready_o,
    input  logic [AW-3:0] ic_req_addr_i,
    output logic          ic_rsp_valid_o,
    output logic [DW-1:0] ic_rsp_data_o,
    output logic          ic_rsp_last_o,
    // dcache
    input  logic          dc_req_valid_i,
    output logic          dc_req_ready_o,
    input  logic [AW-3:0] dc_req_addr_i,
    input  logic          dc_req_rtype_i,
    input  logic [DW-1:0] dc_wdata_i,
    output logic          dc_wdata_ready_o,
    output logic          dc_rsp_valid_o,
    output logic [DW-1:0] dc_rsp_data_o,
    output logic          dc_rsp_last_o,
    output logic          dc_wr_done_o,
    // main memory
    output logic          mem_req_valid_o,
    input  logic          mem_req_ready_i,
    output logic [AW-1:0] mem_req_addr_o,
    output logic          mem_req_we_o,
    output logic [DW-1:0] mem_req_wdata_o,
    input  logic          mem_rsp_valid_i,
    input  logic [DW-1:0] mem_rsp_data_i
);

    localparam int BW = $clog2(BEATS);
    localparam int CW = BW + 1;
    localparam int LW = AW - 2;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_grant_q, last_grant_d;
    logic [LW-1:0] line_addr_q, line_addr_d;
    logic [CW-1:0] iss_cnt_q, iss_cnt_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic          ic_rsp_valid_q, ic_rsp_valid_d;
    logic [DW-1:0] ic_rsp_data_q,  ic_rsp_data_d;
    logic          ic_rsp_last_q,  ic_rsp_last_d;
    logic          dc_rsp_valid_q, dc_rsp_valid_d;
    logic [DW-1:0] dc_rsp_data_q,  dc_rsp_data_d;
    logic          dc_rsp_last_q,  dc_rsp_last_d;
    logic          dc_wr_done_q,   dc_wr_done_d;

    logic          ic_gnt_s;
    logic          dc_gnt_s;
    logic          mem_req_valid_s;
    logic          beat_acc_s;
    logic          rsp_final_s;

    // Beat issue qualifiers: a beat is outstanding while the line is not fully issued.
    always_comb begin
        mem_req_valid_s = ((state_q == ST_RD) || (state_q == ST_WR)) && (iss_cnt_q < CNT_FULL);
        beat_acc_s      = mem_req_valid_s && mem_req_ready_i;
        rsp_final_s     = (rsp_cnt_q == CNT_LAST);
    end

    // Round-robin grant, IDLE only; gated by rst_n so no grant is shown during reset.
    always_comb begin
        ic_gnt_s = 1'b0;
        dc_gnt_s = 1'b0;
        if ((state_q == ST_IDLE) && rst_n) begin
            if (ic_req_valid_i && dc_req_valid_i) begin
                // Tie: the requester that did not win last time goes first.
                if (last_grant_q == OWN_IC) begin
                    dc_gnt_s = 1'b1;
                end else begin
                    ic_gnt_s = 1'b1;
                end
            end else begin
                ic_gnt_s = ic_req_valid_i;
                dc_gnt_s = dc_req_valid_i;
            end
        end else begin
            ic_gnt_s = 1'b0;
            dc_gnt_s = 1'b0;
        end
    end

    // Next-state, counters and registered response/done outputs.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        line_addr_d    = line_addr_q;
        iss_cnt_d      = iss_cnt_q;
        rsp_cnt_d      = rsp_cnt_q;
        ic_rsp_valid_d = 1'b0;
        ic_rsp_last_d  = 1'b0;
        ic_rsp_data_d  = ic_rsp_data_q;
        dc_rsp_valid_d = 1'b0;
        dc_rsp_last_d  = 1'b0;
        dc_rsp_data_d  = dc_rsp_data_q;
        dc_wr_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counters restart for every transaction; stray responses are dropped here.
                iss_cnt_d = CNT_ZERO;
                rsp_cnt_d = CNT_ZERO;
                if (ic_gnt_s) begin
                    state_d      = ST_RD;
                    owner_d      = OWN_IC;
                    last_grant_d = OWN_IC;
                    line_addr_d  = ic_req_addr_i;
                end else if (dc_gnt_s) begin
                    state_d      = dc_req_rtype_i ? ST_WR : ST_RD;
                    owner_d      = OWN_DC;
                    last_grant_d = OWN_DC;
                    line_addr_d  = dc_req_addr_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD: begin
                iss_cnt_d = beat_acc_s ? (iss_cnt_q + CNT_ONE) : iss_cnt_q;
                if (mem_rsp_valid_i) begin
                    rsp_cnt_d = rsp_cnt_q + CNT_ONE;
                    if (owner_q == OWN_IC) begin
                        ic_rsp_valid_d = 1'b1;
                        ic_rsp_data_d  = mem_rsp_data_i;
                        ic_rsp_last_d  = rsp_final_s;
                    end else begin
                        dc_rsp_valid_d = 1'b1;
                        dc_rsp_data_d  = mem_rsp_data_i;
                        dc_rsp_last_d  = rsp_final_s;
                    end
                    state_d = rsp_final_s ? ST_IDLE : ST_RD;
                end else begin
                    rsp_cnt_d = rsp_cnt_q;
                end
            end

            ST_WR: begin
                if (beat_acc_s) begin
                    iss_cnt_d = iss_cnt_q + CNT_ONE;
                    if (iss_cnt_q == CNT_LAST) begin
                        state_d      = ST_IDLE;
                        dc_wr_done_d = 1'b1;
                    end else begin
                        state_d = ST_WR;
                    end
                end else begin
                    iss_cnt_d = iss_cnt_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_IC;
            last_grant_q   <= OWN_IC;
            line_addr_q    <= {LW{1'b0}};
            iss_cnt_q      <= CNT_ZERO;
            rsp_cnt_q      <= CNT_ZERO;
            ic_rsp_valid_q <= 1'b0;
            ic_rsp_data_q  <= {DW{1'b0}};
            ic_rsp_last_q  <= 1'b0;
            dc_rsp_valid_q <= 1'b0;
            dc_rsp_data_q  <= {DW{1'b0}};
            dc_rsp_last_q  <= 1'b0;
            dc_wr_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            line_addr_q    <= line_addr_d;
            iss_cnt_q      <= iss_cnt_d;
            rsp_cnt_q      <= rsp_cnt_d;
            ic_rsp_valid_q <= ic_rsp_valid_d;
            ic_rsp_data_q  <= ic_rsp_data_d;
            ic_rsp_last_q  <= ic_rsp_last_d;
            dc_rsp_valid_q <= dc_rsp_valid_d;
            dc_rsp_data_q  <= dc_rsp_data_d;
            dc_rsp_last_q  <= dc_rsp_last_d;
            dc_wr_done_q   <= dc_wr_done_d;
        end
    end

    // Beat address is the line address with the beat index appended (no carry into the line).
    assign mem_req_addr_o   = AW'({line_addr_q, iss_cnt_q[BW-1:0]});
    assign mem_req_valid_o  = mem_req_valid_s;
    assign mem_req_we_o     = (state_q == ST_WR);
    assign mem_req_wdata_o  = dc_wdata_i;
    assign dc_wdata_ready_o = beat_acc_s && (state_q == ST_WR);

    assign ic_req_ready_o   = ic_gnt_s;
    assign dc_req_ready_o   = dc_gnt_s;
    assign ic_rsp_valid_o   = ic_rsp_valid_q;
    assign ic_rsp_data_o    = ic_rsp_data_q;
    assign ic_rsp_last_o    = ic_rsp_last_q;
    assign dc_rsp_valid_o   = dc_rsp_valid_q;
    assign dc_rsp_data_o    = dc_rsp_data_q;
    assign dc_rsp_last_o    = dc_rsp_last_q;
    assign dc_wr_done_o     = dc_wr_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a small memory model (programmable ready
// pattern and read latency, optional stray response), a monitor that logs
// accepted beats, responses, grants and done pulses with cycle stamps, and a
// main sequence that compares those logs with hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 128;
    localparam int BEATS = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ic_req_valid, ic_req_ready, ic_rsp_valid, ic_rsp_last;
    logic [AW-3:0]   ic_req_addr;
    logic [DW-1:0]   ic_rsp_data;
    logic            dc_req_valid, dc_req_ready, dc_req_rtype, dc_wdata_ready;
    logic            dc_rsp_valid, dc_rsp_last, dc_wr_done;
    logic [AW-3:0]   dc_req_addr;
    logic [DW-1:0]   dc_wdata, dc_rsp_data;
    logic            mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata, mem_rsp_data;

    mem_arbiter #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ic_req_valid_i   (ic_req_valid),
        .ic_req_ready_o   (ic_req_ready),
        .ic_req_addr_i    (ic_req_addr),
        .ic_rsp_valid_o   (ic_rsp_valid),
        .ic_rsp_data_o    (ic_rsp_data),
        .ic_rsp_last_o    (ic_rsp_last),
        .dc_req_valid_i   (dc_req_valid),
        .dc_req_ready_o   (dc_req_ready),
        .dc_req_addr_i    (dc_req_addr),
        .dc_req_rtype_i   (dc_req_rtype),
        .dc_wdata_i       (dc_wdata),
        .dc_wdata_ready_o (dc_wdata_ready),
        .dc_rsp_valid_o   (dc_rsp_valid),
        .dc_rsp_data_o    (dc_rsp_data),
        .dc_rsp_last_o    (dc_rsp_last),
        .dc_wr_done_o     (dc_wr_done),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr),
        .mem_req_we_o     (mem_req_we),
        .mem_req_wdata_o  (mem_req_wdata),
        .mem_rsp_valid_i  (mem_rsp_valid),
        .mem_rsp_data_i   (mem_rsp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory content for a beat address.
    function automatic logic [127:0] data_of(input logic [11:0] a);
        return {8{4'hA, a}};
    endfunction

    // ---------------- memory model (sole driver of mem_req_ready / mem_rsp_*)
    int          lat       = 2;
    logic [5:0]  pat       = 6'b000000;
    int          pat_len   = 0;
    int          pat_gen   = 0;
    int          stray_req = 0;
    int          cyc       = 0;

    typedef struct {
        int           due;
        logic [127:0] d;
    } rsp_t;

    initial begin : mem_model
        rsp_t rsp_q[$];
        rsp_t r;
        int   pat_idx    = 0;
        int   seen_gen   = 0;
        int   stray_done = 0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (seen_gen != pat_gen) begin
                seen_gen = pat_gen;
                pat_idx  = 0;
            end
            mem_rsp_valid = 1'b0;
            if (!rst_n) begin
                rsp_q.delete();
            end
            if (mem_req_valid) begin
                mem_req_ready = (pat_idx < pat_len) ? pat[pat_idx] : 1'b1;
                pat_idx++;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (rst_n && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp_q[0].d;
                void'(rsp_q.pop_front());
            end else if (rst_n && stray_done != stray_req) begin
                stray_done    = stray_req;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = {4{32'h5EA5_0BAD}};
            end
            #1;
            if (rst_n && mem_req_valid && mem_req_ready && !mem_req_we) begin
                r.due = cyc + lat;
                r.d   = data_of(mem_req_addr);
                rsp_q.push_back(r);
            end
        end
    end

    // ---------------- monitor / dcache write-data driver
    logic [127:0] wbuf [4] = '{128'h1111_2222_3333_4444_5555_6666_7777_8888,
                               128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000,
                               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                               128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1357_9BDF};
    logic [11:0]  acc_addr[$];
    logic         acc_we[$];
    int           acc_cyc[$];
    logic [127:0] acc_wd[$];
    logic [127:0] ic_data[$], dc_data[$];
    logic         ic_last[$], dc_last[$];
    int           dc_cyc[$], done_cyc[$], icg_cyc[$], dcg_cyc[$], wrdy_cyc[$];

    initial begin : monitor
        int wbeat = 0;
        dc_wdata = wbuf[0];
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (mem_req_valid && mem_req_ready) begin
                    acc_addr.push_back(mem_req_addr);
                    acc_we.push_back(mem_req_we);
                    acc_cyc.push_back(cyc);
                    acc_wd.push_back(mem_req_wdata);
                end
                if (ic_rsp_valid) begin
                    ic_data.push_back(ic_rsp_data);
                    ic_last.push_back(ic_rsp_last);
                end
                if (dc_rsp_valid) begin
                    dc_data.push_back(dc_rsp_data);
                    dc_last.push_back(dc_rsp_last);
                    dc_cyc.push_back(cyc);
                end
                if (dc_wr_done)   done_cyc.push_back(cyc);
                if (ic_req_ready) icg_cyc.push_back(cyc);
                if (dc_req_ready) dcg_cyc.push_back(cyc);
                // dcache presents the next write beat after each accept
                if (dc_wdata_ready) begin
                    wrdy_cyc.push_back(cyc);
                    wbeat++;
                    dc_wdata = (wbeat < 4) ? wbuf[wbeat] : '0;
                end
                if (dc_req_ready && dc_req_rtype) begin
                    wbeat    = 0;
                    dc_wdata = wbuf[0];
                end
            end
        end
    end

    // ---------------- main sequence helpers
    int m_acc, m_ic, m_dc, m_done, m_icg, m_dcg, m_wrdy;

    task automatic mark_all();
        m_acc  = acc_addr.size();
        m_ic   = ic_data.size();
        m_dc   = dc_data.size();
        m_done = done_cyc.size();
        m_icg  = icg_cyc.size();
        m_dcg  = dcg_cyc.size();
        m_wrdy = wrdy_cyc.size();
    endtask

    // Runs up to n cycles from a negedge, dropping each request after its grant.
    // With stop_ic >= 0 it returns mid-cycle once that many icache beats are logged.
    task automatic run(input int n, input int stop_ic);
        bit ic_seen = 1'b0;
        bit dc_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            #3;
            if (ic_req_ready) ic_seen = 1'b1;
            if (dc_req_ready) dc_seen = 1'b1;
            if (stop_ic >= 0 && ic_data.size() >= stop_ic) return;
            @(negedge clk);
            if (ic_seen) begin
                ic_req_valid = 1'b0;
                ic_seen      = 1'b0;
            end
            if (dc_seen) begin
                dc_req_valid = 1'b0;
                dc_seen      = 1'b0;
            end
        end
    endtask

    task automatic check_rd(input string tag, input bit use_dc, input int mark, input logic [11:0] base);
        int n;
        logic [11:0] a;
        n = use_dc ? (dc_data.size() - mark) : (ic_data.size() - mark);
        check({tag, "_beats"}, n, 4);
        for (int i = 0; i < 4 && i < n; i++) begin
            a = base + 12'(i);
            check({tag, "_data"}, use_dc ? dc_data[mark+i] : ic_data[mark+i], data_of(a));
            check({tag, "_last"}, use_dc ? dc_last[mark+i] : ic_last[mark+i], (i == 3));
        end
    endtask

    task automatic check_acc(input string tag, input int mark, input logic [11:0] base, input logic we);
        int n;
        n = acc_addr.size() - mark;
        check({tag, "_accn"}, (n >= 4), 1'b1);
        for (int i = 0; i < 4 && i < n; i++) begin
            check({tag, "_addr"}, acc_addr[mark+i], base + 12'(i));
            check({tag, "_we"}, acc_we[mark+i], we);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {ic_req_ready, dc_req_ready, ic_rsp_valid, ic_rsp_last,
                              dc_rsp_valid, dc_rsp_last, dc_wdata_ready, dc_wr_done,
                              mem_req_valid, mem_req_we}, 10'b0);
        check({tag, "_addr"}, mem_req_addr, 12'h000);
        check({tag, "_icd"}, ic_rsp_data, 128'h0);
        check({tag, "_dcd"}, dc_rsp_data, 128'h0);
    endtask

    // ---------------- main sequence
    initial begin : main
        int offs [4] = '{0, 2, 3, 5};
        rst_n        = 1'b0;
        ic_req_valid = 1'b0;
        ic_req_addr  = '0;
        dc_req_valid = 1'b0;
        dc_req_addr  = '0;
        dc_req_rtype = 1'b0;

        // Reset state, with requests present so no grant may leak out.
        repeat (2) @(negedge clk);
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        #3;
        check_zero_outputs("reset");
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie right after reset: dcache first, icache in the IDLE cycle after completion.
        @(negedge clk);
        mark_all();
        dc_req_valid = 1'b1; dc_req_addr = 10'h100; dc_req_rtype = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 10'h055;
        run(24, -1);
        check("tie1_dcg_n", dcg_cyc.size() - m_dcg, 1);
        check("tie1_icg_n", icg_cyc.size() - m_icg, 1);
        check("tie1_gap", icg_cyc[m_icg] - dcg_cyc[m_dcg], 7);
        check_rd("tie1_dc", 1'b1, m_dc, 12'h400);
        check_rd("tie1_ic", 1'b0, m_ic, 12'h154);
        check("tie1_lastcyc", dc_cyc[m_dc+3], icg_cyc[m_icg]);
        check_acc("tie1_dcacc", m_acc, 12'h400, 1'b0);
        check_acc("tie1_icacc", m_acc + 4, 12'h154, 1'b0);

        // dcache read line 0x001.
        mark_all();
        dc_req_valid = 1'b1; dc_req_addr = 10'h001; dc_req_rtype = 1'b0;
        run(14, -1);
        check_acc("dcrd", m_acc, 12'h004, 1'b0);
        check_rd("dcrd", 1'b1, m_dc, 12'h004);
        check("dcrd_icbeats", ic_data.size() - m_ic, 0);
        check("dcrd_wrdy", wrdy_cyc.size() - m_wrdy, 0);

        // Tie after a dcache grant: icache wins.
        mark_all();
        dc_req_valid = 1'b1; dc_req_addr = 10'h0F0; dc_req_rtype = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 10'h0AA;
        run(24, -1);
        check("tie2_gap", dcg_cyc[m_dcg] - icg_cyc[m_icg], 7);
        check_acc("tie2_icacc", m_acc, 12'h2A8, 1'b0);
        check_rd("tie2_ic", 1'b0, m_ic, 12'h2A8);
        check_rd("tie2_dc", 1'b1, m_dc, 12'h3C0);

        // icache read line 0x2A, latency 2, ready always.
        mark_all();
        ic_req_valid = 1'b1; ic_req_addr = 10'h02A;
        run(14, -1);
        check_acc("icrd", m_acc, 12'h0A8, 1'b0);
        for (int i = 1; i < 4; i++) check("icrd_b2b", acc_cyc[m_acc+i] - acc_cyc[m_acc], i);
        check_rd("icrd", 1'b0, m_ic, 12'h0A8);
        check("icrd_dcbeats", dc_data.size() - m_dc, 0);
        check("icrd_idle_v", ic_rsp_valid, 1'b0);
        check("icrd_hold", ic_rsp_data, data_of(12'h0AB));

        // dcache write-back line 0x3FF, ready 1,0,1,1,0,1.
        mark_all();
        pat = 6'b101101; pat_len = 6; pat_gen++;
        dc_req_valid = 1'b1; dc_req_addr = 10'h3FF; dc_req_rtype = 1'b1;
        run(16, -1);
        pat_len = 0; pat_gen++;
        check_acc("wr", m_acc, 12'hFFC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("wr_wdata", acc_wd[m_acc+i], wbuf[i]);
            check("wr_acccyc", acc_cyc[m_acc+i] - acc_cyc[m_acc], offs[i]);
        end
        check("wr_wrdy_n", wrdy_cyc.size() - m_wrdy, 4);
        for (int i = 0; i < 4; i++) check("wr_wrdy_cyc", wrdy_cyc[m_wrdy+i], acc_cyc[m_acc+i]);
        check("wr_done_n", done_cyc.size() - m_done, 1);
        check("wr_done_cyc", done_cyc[m_done], acc_cyc[m_acc+3] + 1);
        check("wr_rspbeats", (ic_data.size() - m_ic) + (dc_data.size() - m_dc), 0);

        // Stray response in IDLE, then a latency-1 read overlapping issue.
        mark_all();
        stray_req++;
        run(4, -1);
        check("stray_beats", (ic_data.size() - m_ic) + (dc_data.size() - m_dc), 0);
        lat = 1;
        mark_all();
        ic_req_valid = 1'b1; ic_req_addr = 10'h011;
        run(14, -1);
        check_rd("ovl", 1'b0, m_ic, 12'h044);
        check("ovl_overlap", ic_data.size() > m_ic, 1'b1);
        lat = 2;

        // Reset after 2 of 4 read beats, then a fresh full line.
        mark_all();
        ic_req_valid = 1'b1; ic_req_addr = 10'h123;
        run(20, m_ic + 2);
        check("mid_reach", ic_data.size() - m_ic, 2);
        check("mid_vld_pre", ic_rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        ic_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mark_all();
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 10'h0C3;
        run(16, -1);
        check_rd("postrst", 1'b0, m_ic, 12'h30C);
        check("postrst_done", done_cyc.size() - m_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit main-memory port between icache (line reads only) and dcache (line reads and dirty-line write-backs).
- Arbitrates whole cache-line transactions round-robin.
- Sequences each line as BEATS memory beats and routes the in-order read responses back to the owning cache.
- Sits between the icache/dcache miss/evict FSMs and main memory.

Parameters:
AW, 12, memory beat address width (MEM_ADDR_BUS); line address width is AW-2
DW, 128, memory data width (MEM_DATA_BUS)
BEATS, 4, beats per cache line (MEM_TRANSFERS_PER_CL); must be a power of 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
ic_req_valid  in  1  icache line-read request
ic_req_ready  out  1  icache request accepted (grant pulse)
ic_req_addr  in  AW-2  icache line address
ic_rsp_valid  out  1  icache read beat valid
ic_rsp_data  out  DW  icache read beat data
ic_rsp_last  out  1  final beat of line
dc_req_valid  in  1  dcache request
dc_req_ready  out  1  dcache request accepted (grant pulse)
dc_req_addr  in  AW-2  dcache line address
dc_req_rtype  in  1  0 = DMEM_READ, 1 = DMEM_WRITE
dc_wdata  in  DW  write beat data, current beat index
dc_wdata_ready  out  1  current write beat accepted by memory
dc_rsp_valid  out  1  dcache read beat valid
dc_rsp_data  out  DW  dcache read beat data
dc_rsp_last  out  1  final read beat of line
dc_wr_done  out  1  write-back complete pulse
mem_req_valid  out  1  memory beat request
mem_req_ready  in  1  memory accepts beat
mem_req_addr  out  AW  beat address {line_addr, beat_idx}
mem_req_we  out  1  beat is a write
mem_req_wdata  out  DW  write beat data (= dc_wdata)
mem_rsp_valid  in  1  read beat returned, in order
mem_rsp_data  in  DW  read beat data

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transaction):
  - State goes to IDLE; counters and captured address clear; owner and last_grant set to IC.
  - All outputs go to 0.
  - An in-flight transaction is abandoned; no done or last pulse is emitted.
- States and transitions:
  - IDLE -> RD when a read is granted (ic, or dc with rtype = 0).
  - IDLE -> WR when a dc write is granted.
  - RD -> IDLE on the clock edge that captures response number BEATS.
  - WR -> IDLE on the clock edge that accepts write beat number BEATS.
- Arbitration (IDLE only):
  - A single valid requester is granted.
  - If both are valid, the requester not equal to last_grant wins; after reset the dcache wins the first tie.
  - Grant: req_ready is high combinationally for exactly that cycle. Line address, owner and rtype are captured; last_grant updates.
  - Requesters hold valid and addr stable until ready. Dropping valid early is illegal and not checked.
  - No grants in RD or WR. The other requester waits; it is granted in the next IDLE cycle, so there is exactly one IDLE cycle between transactions.
- Issue counter iss_cnt (0..BEATS):
  - mem_req_valid = (RD or WR) and iss_cnt < BEATS.
  - mem_req_addr = {line_addr, iss_cnt[log2(BEATS)-1:0]}.
  - iss_cnt increments on mem_req_valid & mem_req_ready.
  - Beats issue back-to-back, one per cycle when ready stays high.
  - mem_req_we = (state == WR).
  - mem_req_wdata = dc_wdata, combinational.
- WR:
  - dc_wdata_ready = mem_req_valid & mem_req_ready; the dcache advances to the next beat after each pulse.
  - dc_wr_done pulses for 1 cycle, registered, the cycle after the BEATS-th accept.
- RD, response counter rsp_cnt (0..BEATS):
  - rsp_cnt increments on mem_rsp_valid.
  - A response may arrive in the same cycle as a request accept.
  - Responses are registered, giving 1-cycle latency. The owner's rsp_valid and rsp_data are set from mem_rsp_*; the other requester's rsp_valid stays 0.
  - rsp_last is set with the BEATS-th response.
  - rsp_data holds its last value while rsp_valid is low.
- Unexpected traffic:
  - mem_rsp_valid in IDLE or WR is ignored and does not update counters or outputs.
  - mem_rsp_valid beyond BEATS cannot occur, because the state has left RD.
- Widths: counters are log2(BEATS)+1 bits and do not wrap, since they saturate by leaving the state. The address does not carry into the line bits.

Test Plan:
- ic read, line 0x2A, mem ready always, response latency 2 -> mem addrs 0xA8,0xA9,0xAA,0xAB on consecutive cycles; 4 ic_rsp_valid beats with data matching in order; ic_rsp_last on the 4th; dc_rsp_valid stays 0.
- dc write-back, line 0x3FF, mem_req_ready toggling 1,0,1,1,0,1 -> we=1; addrs 0xFFC..0xFFF; 4 dc_wdata_ready pulses aligned to accepts; dc_wr_done 1 cycle after the 4th accept.
- ic and dc (read) valid in the same cycle right after reset -> dc granted first; ic_req_ready 1 cycle after dc completion plus one IDLE cycle; next tie grants the opposite requester.
- Read with responses arriving while beats are still issuing, plus a stray mem_rsp_valid in IDLE -> exactly 4 beats delivered; stray response produces no rsp_valid.
- rst_n asserted after 2 of 4 read beats -> all outputs 0 immediately; a fresh ic request after release completes a full 4-beat line normally.
- dc read line 0x001 -> dc_rsp_valid x4, dc_wdata_ready never asserted, mem_req_we = 0.
